// File: rtl/sdspi_arb_pkg.sv
// Shared types and helpers for the SD-card SPI bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GUARD, OWNED)
//   MODE_*      : arbitration policy encodings for the MODE parameter
//   idx_w()     : width of a master index for a given channel count
package sdspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        OWNED = 2'd2
    } arb_state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Never return 0 so a single-bit index still exists for tiny configs.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arb_picker.sv
// Combinational winner selection for the SPI bus arbiter.
//   req     : per-master request vector
//   rr_ptr  : index of the most recent owner (round-robin start point)
//   rr_mode : 0 = lowest set index wins, 1 = first set index after rr_ptr
//   winner  : selected master index (0 when nothing is requested)
//   valid   : at least one request is set
module spi_arb_picker
    import sdspi_arb_pkg::*;
#(
    parameter  int N_CH  = 2,
    localparam int IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             rr_mode,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Both scans walk from lowest to highest priority so that the last hit,
    // which overwrites earlier ones, is the highest-priority requester.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        if (rr_mode) begin
            for (int k = N_CH; k >= 1; k--) begin
                idx = IDX_W'((int'(rr_ptr) + k) % N_CH);
                if (req[idx]) begin
                    valid  = 1'b1;
                    winner = idx;
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                idx = IDX_W'(i);
                if (req[idx]) begin
                    valid  = 1'b1;
                    winner = idx;
                end
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// N-channel SPI master arbiter sharing one SD-card pad set.
// Ownership changes only while the bus is idle, separated by a guard interval
// with the pads parked at idle levels so the card never sees a glitched edge.
//   req_i/gnt_o          : level request and one-hot grant per master
//   cs_i/sclk_i/mosi_i   : per-master SPI outputs, muxed to the pads when owned
//   cs/sclk/mosi/miso    : pad side
//   miso_o               : miso to the owner, 1 to everybody else
//   owner_o              : current or pending owner index
//   busy_o               : arbiter not idle
//   switch_cnt_o         : completed grants, wrapping 16-bit counter
module spi_bus_arbiter
    import sdspi_arb_pkg::*;
#(
    parameter  int   N_CH         = 2,
    parameter  int   GUARD_CYCLES = 4,
    parameter  int   MODE         = MODE_FIXED,
    parameter  logic CPOL         = 1'b0,
    localparam int   IDX_W        = idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req_i,
    output logic [N_CH-1:0]  gnt_o,
    input  logic [N_CH-1:0]  cs_i,
    input  logic [N_CH-1:0]  sclk_i,
    input  logic [N_CH-1:0]  mosi_i,
    output logic             cs,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic [N_CH-1:0]  miso_o,
    output logic [IDX_W-1:0] owner_o,
    output logic             busy_o,
    output logic [15:0]      switch_cnt_o
);

    localparam int               CNT_W      = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      switch_cnt, switch_cnt_n;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic             own_req, own_cs, own_sclk, own_mosi;
    logic             owned;
    logic [N_CH-1:0]  sel;

    spi_arb_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .req     (req_i),
        .rr_ptr  (rr_ptr),
        .rr_mode (MODE == MODE_RR),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    // Signals of the registered owner. Indices with no master behind them
    // fall through to idle levels.
    // NOTE: every variable gets a default before any branch; otherwise an
    // unassigned path would hold its old value and infer a latch.
    always_comb begin
        own_req  = 1'b0;
        own_cs   = 1'b1;
        own_sclk = CPOL;
        own_mosi = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (owner == IDX_W'(i)) begin
                own_req  = req_i[i];
                own_cs   = cs_i[i];
                own_sclk = sclk_i[i];
                own_mosi = mosi_i[i];
            end
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        rr_ptr_n     = rr_ptr;
        cnt_n        = cnt;
        switch_cnt_n = switch_cnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_n = pick_idx;
                    cnt_n   = GUARD_LOAD;
                    state_n = GUARD;
                end
            end
            GUARD: begin
                // A requester that gives up during the guard forfeits the
                // slot; other requests wait for the next IDLE arbitration.
                if (!own_req) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n      = OWNED;
                    switch_cnt_n = switch_cnt + 16'd1;
                    if (MODE == MODE_RR) begin
                        rr_ptr_n = owner;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            OWNED: begin
                // Hold the bus until the owner has both withdrawn its request
                // and deasserted CS, so a transfer is never cut short.
                if (!own_req && own_cs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= IDX_W'(N_CH - 1);
            cnt        <= '0;
            switch_cnt <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            rr_ptr     <= rr_ptr_n;
            cnt        <= cnt_n;
            switch_cnt <= switch_cnt_n;
        end
    end

    // Pads and grants decode straight from registered state so the SPI path
    // carries no extra latency and an async reset idles the pads at once.
    assign owned = (state == OWNED);

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel[i] = owned && (owner == IDX_W'(i));
        end
    end

    assign gnt_o        = sel;
    assign miso_o       = ~sel | {N_CH{miso}};
    assign cs           = owned ? own_cs   : 1'b1;
    assign sclk         = owned ? own_sclk : CPOL;
    assign mosi         = owned ? own_mosi : 1'b1;
    assign owner_o      = owner;
    assign busy_o       = (state != IDLE);
    assign switch_cnt_o = switch_cnt;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Testbench for spi_bus_arbiter: fixed-priority and round-robin 4-channel
// instances with grant scoreboards, plus a 2-channel instance for counter wrap.
module tb_spi_bus_arbiter;

    typedef struct {
        int          at;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [15:0] swc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t f_q[$];
    exp_t r_q[$];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Fixed-priority instance
    logic [3:0]  f_req, f_cs, f_sclk, f_mosi, f_gnt, f_miso_o;
    logic        f_miso, f_cs_p, f_sclk_p, f_mosi_p, f_busy;
    logic [1:0]  f_owner;
    logic [15:0] f_swc;

    spi_bus_arbiter #(.N_CH(4), .GUARD_CYCLES(4), .MODE(0), .CPOL(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .req_i(f_req), .gnt_o(f_gnt),
        .cs_i(f_cs), .sclk_i(f_sclk), .mosi_i(f_mosi),
        .cs(f_cs_p), .sclk(f_sclk_p), .mosi(f_mosi_p), .miso(f_miso),
        .miso_o(f_miso_o), .owner_o(f_owner), .busy_o(f_busy), .switch_cnt_o(f_swc)
    );

    // Round-robin instance
    logic [3:0]  r_req, r_cs, r_sclk, r_mosi, r_gnt, r_miso_o;
    logic        r_miso, r_cs_p, r_sclk_p, r_mosi_p, r_busy;
    logic [1:0]  r_owner;
    logic [15:0] r_swc;

    spi_bus_arbiter #(.N_CH(4), .GUARD_CYCLES(4), .MODE(1), .CPOL(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .req_i(r_req), .gnt_o(r_gnt),
        .cs_i(r_cs), .sclk_i(r_sclk), .mosi_i(r_mosi),
        .cs(r_cs_p), .sclk(r_sclk_p), .mosi(r_mosi_p), .miso(r_miso),
        .miso_o(r_miso_o), .owner_o(r_owner), .busy_o(r_busy), .switch_cnt_o(r_swc)
    );

    // Short-guard instance for the counter wrap
    logic [1:0]  w_req, w_cs, w_sclk, w_mosi, w_gnt, w_miso_o;
    logic        w_miso, w_cs_p, w_sclk_p, w_mosi_p, w_busy;
    logic        w_owner;
    logic [15:0] w_swc;

    spi_bus_arbiter #(.N_CH(2), .GUARD_CYCLES(1), .MODE(0), .CPOL(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_i(w_req), .gnt_o(w_gnt),
        .cs_i(w_cs), .sclk_i(w_sclk), .mosi_i(w_mosi),
        .cs(w_cs_p), .sclk(w_sclk_p), .mosi(w_mosi_p), .miso(w_miso),
        .miso_o(w_miso_o), .owner_o(w_owner), .busy_o(w_busy), .switch_cnt_o(w_swc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Grant monitors: every rising grant pops one expected grant record.
    logic [3:0] f_gnt_prev = '0;
    logic [3:0] r_gnt_prev = '0;

    always @(posedge clk) begin : mon_f
        exp_t e;
        #1;
        if (f_gnt != 4'b0000 && f_gnt_prev == 4'b0000) begin
            if (f_q.size() == 0) begin
                check("f_unexpected_grant", 32'(f_gnt), 32'h0);
            end else begin
                e = f_q.pop_front();
                check("f_grant_vec",   32'(f_gnt),   32'(e.gnt));
                check("f_grant_owner", 32'(f_owner), 32'(e.owner));
                check("f_grant_count", 32'(f_swc),   32'(e.swc));
                check("f_grant_cycle", cyc,          e.at);
            end
        end
        f_gnt_prev = f_gnt;
    end

    always @(posedge clk) begin : mon_r
        exp_t e;
        #1;
        if (r_gnt != 4'b0000 && r_gnt_prev == 4'b0000) begin
            if (r_q.size() == 0) begin
                check("r_unexpected_grant", 32'(r_gnt), 32'h0);
            end else begin
                e = r_q.pop_front();
                check("r_grant_vec",   32'(r_gnt),   32'(e.gnt));
                check("r_grant_owner", 32'(r_owner), 32'(e.owner));
                check("r_grant_count", 32'(r_swc),   32'(e.swc));
                check("r_grant_cycle", cyc,          e.at);
            end
        end
        r_gnt_prev = r_gnt;
    end

    initial begin
        rst_n  = 1'b0;
        f_req  = '0; f_cs = 4'b1111; f_sclk = '0; f_mosi = 4'b1111; f_miso = 1'b1;
        r_req  = '0; r_cs = 4'b1111; r_sclk = '0; r_mosi = 4'b1111; r_miso = 1'b1;
        w_req  = '0; w_cs = 2'b11;   w_sclk = '0; w_mosi = 2'b11;   w_miso = 1'b1;
        #1;
        check("rst_f_gnt",   32'(f_gnt),   32'h0);
        check("rst_f_owner", 32'(f_owner), 32'h0);
        check("rst_f_swc",   32'(f_swc),   32'h0);
        check("rst_f_busy",  32'(f_busy),  32'h0);
        check("rst_f_pads",  32'({f_cs_p, f_sclk_p, f_mosi_p}), 32'b101);
        check("rst_f_miso",  32'(f_miso_o), 32'hF);
        check("rst_r_state", 32'({r_gnt, r_owner, r_busy, r_swc}), 32'h0);
        check("rst_r_pads",  32'({r_cs_p, r_sclk_p, r_mosi_p, r_miso_o}), 32'b101_1111);
        check("rst_w_state", 32'({w_gnt, w_owner, w_busy, w_swc}), 32'h0);
        check("rst_w_pads",  32'({w_cs_p, w_sclk_p, w_mosi_p, w_miso_o}), 32'b101_11);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        f_req = 4'b0011;
        r_req = 4'b1111;
        f_q.push_back('{at: 6, gnt: 4'b0001, owner: 2'd0, swc: 16'd1});

        fork
            begin : fixed_seq
                to_cyc(1);  f_cs = 4'b1110;
                to_cyc(3);
                check("guard_busy",  32'(f_busy), 32'h1);
                check("guard_gnt",   32'(f_gnt),  32'h0);
                check("guard_owner", 32'(f_owner), 32'h0);
                check("guard_pads",  32'({f_cs_p, f_sclk_p, f_mosi_p}), 32'b101);
                to_cyc(6);
                check("own0_cs", 32'(f_cs_p), 32'h0);
                f_sclk = 4'b0001; f_mosi = 4'b1110; f_miso = 1'b0;
                #1;
                check("own0_sclk", 32'(f_sclk_p), 32'h1);
                check("own0_mosi", 32'(f_mosi_p), 32'h0);
                check("own0_miso", 32'(f_miso_o), 32'hE);
                f_miso = 1'b1;
                to_cyc(10); check("no_preempt", 32'(f_gnt), 32'h1);
                to_cyc(12); f_req = 4'b0010;
                to_cyc(14);
                check("hold_cs_low", 32'(f_gnt), 32'h1);
                f_cs = 4'b1101; f_sclk = '0; f_mosi = 4'b1111;
                f_q.push_back('{at: 21, gnt: 4'b0010, owner: 2'd1, swc: 16'd2});
                to_cyc(15);
                check("rel0_gnt",  32'(f_gnt),  32'h0);
                check("rel0_busy", 32'(f_busy), 32'h0);
                check("rel0_cs",   32'(f_cs_p), 32'h1);
                to_cyc(16);
                check("pend1_owner", 32'(f_owner), 32'h1);
                check("pend1_busy",  32'(f_busy),  32'h1);
                to_cyc(18); check("handoff_cs_idle", 32'(f_cs_p), 32'h1);
                to_cyc(21); check("own1_cs", 32'(f_cs_p), 32'h0);
                to_cyc(22); f_req = 4'b0000; f_sclk = 4'b0010;
                for (int c = 23; c <= 32; c++) begin
                    to_cyc(c);
                    check("held_gnt",  32'(f_gnt),    32'h2);
                    check("held_pads", 32'({f_cs_p, f_sclk_p}), 32'b01);
                end
                f_cs = 4'b1111;
                to_cyc(33);
                check("rel1_gnt",  32'(f_gnt),  32'h0);
                check("rel1_pads", 32'({f_cs_p, f_sclk_p, f_mosi_p}), 32'b101);
                check("rel1_swc",  32'(f_swc),  32'h2);
                to_cyc(34); f_req = 4'b0010;
                to_cyc(37); f_req = 4'b0000;
                to_cyc(38);
                check("abort_busy", 32'(f_busy), 32'h0);
                check("abort_gnt",  32'(f_gnt),  32'h0);
                check("abort_swc",  32'(f_swc),  32'h2);
                to_cyc(40);
                f_req = 4'b1100;
                f_q.push_back('{at: 46, gnt: 4'b0100, owner: 2'd2, swc: 16'd3});
                to_cyc(46); f_req = 4'b0000;
                to_cyc(47);
                check("rel2_gnt", 32'(f_gnt), 32'h0);
                check("rel2_swc", 32'(f_swc), 32'h3);
                to_cyc(48);
                f_req = 4'b1000; f_cs = 4'b0111;
                f_q.push_back('{at: 54, gnt: 4'b1000, owner: 2'd3, swc: 16'd4});
                to_cyc(56);
                check("own3_cs", 32'(f_cs_p), 32'h0);
            end
            begin : rr_seq
                for (int n = 0; n < 5; n++) begin
                    int k;
                    int wait_cnt;
                    k = n % 4;
                    r_q.push_back('{at: 6 + 9 * n, gnt: 4'(1 << k), owner: 2'(k), swc: 16'(n + 1)});
                    wait_cnt = 0;
                    while (r_gnt == 4'b0000 && wait_cnt < 40) begin
                        @(negedge clk);
                        wait_cnt++;
                    end
                    if (wait_cnt >= 40) check("rr_grant_timeout", 32'(r_gnt), 32'(1 << k));
                    @(negedge clk);
                    @(negedge clk);
                    if (n == 4) r_req = 4'b0000;
                    else        r_req[k] = 1'b0;
                    @(negedge clk);
                    if (n < 4) r_req[k] = 1'b1;
                end
            end
        join

        check("rr_swc",  32'(r_swc),  32'd5);
        check("rr_busy", 32'(r_busy), 32'h0);

        // Asynchronous reset in mid-transfer, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pads",  32'({f_cs_p, f_sclk_p, f_mosi_p}), 32'b101);
        check("arst_gnt",   32'(f_gnt),   32'h0);
        check("arst_swc",   32'(f_swc),   32'h0);
        check("arst_busy",  32'(f_busy),  32'h0);
        check("arst_owner", 32'(f_owner), 32'h0);
        f_req = '0; f_cs = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;

        // 65535 grants, then one more to wrap the counter.
        for (int g = 0; g < 65536; g++) begin
            w_req = 2'b01;
            repeat (3) @(negedge clk);
            if (g == 65535) check("wrap_gnt", 32'(w_gnt), 32'h1);
            w_req = 2'b00;
            @(negedge clk);
            if (g == 65534) check("wrap_pre", 32'(w_swc), 32'hFFFF);
        end
        check("wrap_post", 32'(w_swc), 32'h0);

        check("f_queue_left", f_q.size(), 0);
        check("r_queue_left", r_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
N-channel SPI master arbiter. It generalises the two-way autotest/UUT select into a request/grant arbiter. Up to N_CH SPI masters (autotest controller, sdspi_system instances, future cores) share one SD-card SPI pad set. Ownership changes only when the bus is idle, with a guard interval in which the pads sit at idle levels, so the card never sees a glitched CS or SCLK edge. It sits at top level between the masters and the cs/sclk/mosi/miso pads.

Parameters:
N_CH, 2, number of masters (2..16)
GUARD_CYCLES, 4, idle cycles driven between owners (>=1)
MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
CPOL, 0, SCLK idle level driven when no owner

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_i  in  N_CH  per-master bus request, level
gnt_o  out  N_CH  per-master grant, one-hot or zero
cs_i  in  N_CH  per-master chip select (active low)
sclk_i  in  N_CH  per-master SCLK
mosi_i  in  N_CH  per-master MOSI
cs  out  1  pad CS
sclk  out  1  pad SCLK
mosi  out  1  pad MOSI
miso  in  1  pad MISO
miso_o  out  N_CH  MISO fan-out; owner gets miso, all others get 1
owner_o  out  IDX_W  index of current or pending owner, IDX_W = $clog2(N_CH)
busy_o  out  1  state != IDLE
switch_cnt_o  out  16  number of completed grants; wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; gnt_o=0, owner_o=0, switch_cnt_o=0, busy_o=0.
  - rr pointer = N_CH-1, so index 0 is highest priority first.
  - Pads: cs=1, sclk=CPOL, mosi=1.
- States: IDLE, GUARD, OWNED. The owner index is registered. Pad outputs are a combinational mux from the registered owner and the registered state, so the SPI path adds no latency.
- Pad outputs in IDLE and GUARD: cs=1, sclk=CPOL, mosi=1. Pad outputs in OWNED: cs/sclk/mosi = cs_i/sclk_i/mosi_i[owner].
- IDLE:
  - If any req_i bit is set at edge E0: latch winner into owner, load cnt=GUARD_CYCLES, go to GUARD.
  - Fixed mode: winner is the lowest set index.
  - Round-robin mode: winner is the first set index after the rr pointer, scanning upward with wrap.
- GUARD:
  - cnt decrements each edge.
  - On the edge where cnt==0: go to OWNED, set gnt_o[owner]=1, increment switch_cnt_o, and in MODE 1 set rr pointer = owner.
  - gnt_o therefore rises after edge E0+GUARD_CYCLES+1.
  - If req_i[owner] drops during GUARD: return to IDLE next edge with no grant and no count increment. Requests from other masters are ignored during GUARD.
- OWNED:
  - Release condition: req_i[owner]==0 AND cs_i[owner]==1, both sampled at the same edge.
  - On release: gnt_o cleared and state goes to IDLE at that edge. Pads return to idle levels in the same cycle.
  - If req drops while cs_i[owner]==0, ownership is held until cs_i rises. A transfer is never truncated.
  - Requests from other masters never pre-empt the owner.
- Back-to-back handoff: a waiting request is arbitrated in the first IDLE cycle after release. Minimum pad idle time between owners is therefore GUARD_CYCLES+2 clocks.
- miso_o is combinational: miso routed to the owner only while OWNED; every other bit is 1.
- Reset asserted mid-transfer: pads go idle immediately (async); grant is lost.
- Out-of-range owner values cannot occur. Unused decode paths drive idle levels.

Decomposition:
- Package sdspi_arb_pkg:
  - arb_state_t enum {IDLE, GUARD, OWNED}
  - MODE_FIXED=0, MODE_RR=1
  - localparam function for IDX_W
- Sub-module spi_arb_picker:
  - Combinational.
  - Inputs: req vector, rr pointer, mode.
  - Outputs: winner index and valid.
  - Instantiated once; unit-testable on its own.

Test Plan:
- Reset, GUARD_CYCLES=4: req_i=0b01 asserted before edge 1 -> gnt_o=0b01 after edge 6, owner_o=0, switch_cnt_o=1. cs/sclk/mosi = 1/0/1 until then, then follow master 0.
- Fixed mode, req_i=0b11 simultaneously -> master 0 granted. Master 0 releases with cs_i[0]=1 -> gnt_o=0, pads idle for 6 clocks, then gnt_o=0b10.
- MODE=1, N_CH=4, all four req held and each owner releases after 3 cycles -> grant order 0,1,2,3,0; switch_cnt_o=5.
- Owner drops req while cs_i=0 for 10 more cycles -> gnt held 10 cycles; release on the edge cs_i rises; pads never show cs low with sclk forced idle.
- req_i[1] dropped during GUARD, cnt=2 -> back to IDLE, gnt_o never asserted, switch_cnt_o unchanged.
- rst_n pulled low while OWNED with cs=0 -> cs=1, gnt_o=0, switch_cnt_o=0 immediately without a clock edge.
- switch_cnt_o preloaded via 65535 grants -> next grant wraps it to 0.
